spi_debug_port: RTL and testbench
=================================

SPI_DEBUG_PORT -- requirements
Module: spi_debug_port

Interface
Parameters
REQ-001 The block SHALL have parameter NB_BITS, default 32: SPI word, memory word and latch channel width.
REQ-002 The block SHALL have parameter N_CH, default 4: number of latched debug channels, range 1..15.
REQ-003 The block SHALL have parameter NB_ADDR, default 8: data-memory word-address width, range 1..16.
REQ-004 The block SHALL have parameter MEM_LAT, default 1: data-memory read latency in cycles, range 1..4.

Ports
REQ-005 The block SHALL have port i_clock, input, 1 bit: the single clock. All logic SHALL be on the rising edge.
REQ-006 The block SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port i_req_valid, input, 1 bit: single-cycle strobe from the SPI slave that a request word is received.
REQ-008 The block SHALL have port i_req, input, NB_BITS: the request word.
REQ-009 The block SHALL have port i_latch, input, N_CH*NB_BITS: flattened debug channels; channel k occupies bits [(k+1)*NB_BITS-1 : k*NB_BITS].
REQ-010 The block SHALL have port o_mem_addr, output, NB_ADDR: data-memory port-2 address.
REQ-011 The block SHALL have port o_mem_rd, output, 1 bit: read-enable strobe to the data memory.
REQ-012 The block SHALL have port i_mem_data, input, NB_BITS: memory read data, valid MEM_LAT cycles after the o_mem_rd cycle.
REQ-013 The block SHALL have port o_tx_data, output, NB_BITS: word to be loaded into the SPI slave.
REQ-014 The block SHALL have port o_tx_valid, output, 1 bit: o_tx_data is valid.
REQ-015 The block SHALL have port i_tx_ready, input, 1 bit: the SPI slave accepts a word. A transfer occurs when o_tx_valid and i_tx_ready are both high.
REQ-016 The block SHALL have port o_busy, output, 1 bit: a request is in progress.
REQ-017 The block SHALL have port o_req_drop, output, 1 bit: one-cycle pulse when a request is ignored.
REQ-018 The block SHALL have port o_err, output, 1 bit: one-cycle pulse when a request has an invalid source.

Function
REQ-019 Request format SHALL be:
- bits [15:0]: start address; only [NB_ADDR-1:0] are used.
- bits [23:16]: burst length minus 1 (LEN).
- bits [27:24]: source SRC; 0 = memory, 1..N_CH = latch channel SRC-1.
- all other bits ignored.
REQ-020 An i_req_valid pulse in IDLE SHALL be accepted. On acceptance the block SHALL:
- snapshot all of i_latch, so returned latch data is coherent to that cycle;
- assert o_busy from the next cycle.
REQ-021 An i_req_valid pulse while o_busy is high SHALL be ignored, and o_req_drop SHALL pulse on the next cycle.
REQ-022 The FSM SHALL have states IDLE, MEM_ISSUE, MEM_WAIT and PRESENT.
REQ-023 Transitions SHALL be:
- IDLE -> MEM_ISSUE on acceptance with SRC=0.
- IDLE -> PRESENT on acceptance with 1<=SRC<=N_CH.
- MEM_ISSUE -> MEM_WAIT.
- MEM_WAIT -> PRESENT after MEM_LAT cycles.
- PRESENT -> IDLE or MEM_ISSUE on transfer, per REQ-027.
REQ-024 In MEM_ISSUE, o_mem_rd SHALL be high for exactly one cycle with o_mem_addr equal to the current address. i_mem_data SHALL be captured into o_tx_data MEM_LAT cycles later.
REQ-025 For latch sources, o_tx_data SHALL equal the snapshot of channel SRC-1. LEN SHALL be ignored, and exactly one word is returned.
REQ-026 In PRESENT, o_tx_valid SHALL be high and o_tx_data SHALL be held stable until a transfer occurs. o_tx_valid SHALL drop the cycle after the transfer.
REQ-027 For memory bursts:
- after each transfer the remaining count SHALL decrement, and the address SHALL increment modulo 2^NB_ADDR (wrap from all-ones to 0);
- the FSM SHALL return to MEM_ISSUE while the count is non-zero, else go to IDLE;
- exactly LEN+1 words SHALL be returned.
REQ-028 A request with SRC=0 and LEN=0 SHALL return one word.
REQ-029 A request with SRC>N_CH SHALL not change state. o_err SHALL pulse, and no word is returned.
REQ-030 o_busy SHALL be low exactly when the state is IDLE.
REQ-031 i_tx_ready asserted outside PRESENT SHALL have no effect.

Reset
REQ-032 On i_reset, at the next edge:
- state SHALL be IDLE;
- o_tx_data, o_mem_addr, the count and the snapshot SHALL be 0;
- o_tx_valid, o_mem_rd, o_busy, o_req_drop and o_err SHALL be 0.
REQ-033 Reset SHALL abort any burst, including one mid-MEM_WAIT or mid-PRESENT.
REQ-034 Memory data arriving after a reset SHALL be discarded.
REQ-035 The first request accepted after reset SHALL behave as after power-up.

Structure
REQ-036 The source codes (SRC_MEM=0), the request field offsets and the FSM state encodings SHALL reside in a shared debug-port package/include.
REQ-037 The MEM_LAT delay counter MAY be a sub-module named spi_debug_lat_cnt. All other logic SHALL be in spi_debug_port.

Verification
REQ-038 Memory single read: mem[5]=0xCAFE0005; request 0x00000005; i_tx_ready=1 -> one o_mem_rd with addr 5; o_tx_data=0xCAFE0005 after MEM_LAT; o_busy falls after the transfer.
REQ-039 Memory burst with wrap: NB_ADDR=8; request 0x000302FE (LEN=3, start 0xFE) -> words from addresses 0xFE, 0xFF, 0x00, 0x01 in order; 4 transfers.
REQ-040 Latch snapshot: channel 2 = 0x11112222 at acceptance, changed to 0x0 the next cycle; request 0x03000000 -> o_tx_data=0x11112222.
REQ-041 Backpressure: i_tx_ready held low 10 cycles in PRESENT -> o_tx_valid and o_tx_data stable; exactly one transfer when ready rises.
REQ-042 Collision and error: i_req_valid during a burst -> o_req_drop pulse, burst unaffected. With N_CH=4, request 0x07000000 -> o_err pulse, no o_tx_valid.
REQ-043 Reset mid-burst: i_reset asserted in MEM_WAIT of the 2nd word -> all outputs 0 next cycle; a new request completes normally.

Source files
------------

// File: rtl/spi_debug_port_pkg.sv
// spi_debug_port_pkg: source codes, request field layout and FSM encodings shared by the debug port
package spi_debug_port_pkg;
    localparam logic [3:0] SRC_MEM = 4'd0;
    localparam int ADDR_LSB = 0;
    localparam int LEN_LSB = 16;
    localparam int LEN_W = 8;
    localparam int SRC_LSB = 24;
    localparam int SRC_W = 4;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MEM_ISSUE = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] ST_PRESENT = 2'd3;
endpackage

// File: rtl/spi_debug_lat_cnt.sv
// spi_debug_lat_cnt: counts memory read latency, o_done high on the cycle read data is valid
module spi_debug_lat_cnt #(
    parameter int MEM_LAT = 1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_start,
    output logic o_done
);
    logic [1:0] cnt;

    assign o_done = cnt == 2'(MEM_LAT - 1);

    // restart on each issued read, then count up and hold at the latency limit
    always_ff @(posedge i_clock) begin
        if (i_reset || i_start) cnt <= '0;
        else if (!o_done) cnt <= cnt + 2'd1;
    end
endmodule

// File: rtl/spi_debug_port.sv
// spi_debug_port: answers SPI debug requests with memory bursts or snapshotted latch channels
module spi_debug_port
    import spi_debug_port_pkg::*;
#(
    parameter int NB_BITS = 32,
    parameter int N_CH    = 4,
    parameter int NB_ADDR = 8,
    parameter int MEM_LAT = 1
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_req_valid,
    input  logic [NB_BITS-1:0]      i_req,
    input  logic [N_CH*NB_BITS-1:0] i_latch,
    output logic [NB_ADDR-1:0]      o_mem_addr,
    output logic                    o_mem_rd,
    input  logic [NB_BITS-1:0]      i_mem_data,
    output logic [NB_BITS-1:0]      o_tx_data,
    output logic                    o_tx_valid,
    input  logic                    i_tx_ready,
    output logic                    o_busy,
    output logic                    o_req_drop,
    output logic                    o_err
);
    logic [1:0]              state;
    logic [LEN_W-1:0]        cnt;
    logic [SRC_W-1:0]        ch;
    logic                    lat;
    logic [NB_BITS-1:0]      mem_word;
    logic [N_CH*NB_BITS-1:0] snap;
    logic [SRC_W-1:0]        src;
    logic                    accept;
    logic                    lat_done;
    logic                    unused_req;

    assign unused_req = ^i_req;
    assign src        = i_req[SRC_LSB +: SRC_W];
    assign accept     = i_req_valid && state == ST_IDLE;
    assign o_busy     = state != ST_IDLE;
    assign o_tx_valid = state == ST_PRESENT;
    assign o_mem_rd   = state == ST_MEM_ISSUE;
    assign o_tx_data  = lat ? snap[int'(ch)*NB_BITS +: NB_BITS] : mem_word;

    spi_debug_lat_cnt #(.MEM_LAT(MEM_LAT)) u_lat (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_start (o_mem_rd),
        .o_done  (lat_done)
    );

    // request acceptance, burst sequencing and status pulses
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            ch         <= '0;
            lat        <= 1'b0;
            mem_word   <= '0;
            snap       <= '0;
            o_mem_addr <= '0;
            o_req_drop <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_req_drop <= i_req_valid && state != ST_IDLE;
            o_err      <= accept && src > SRC_W'(N_CH);
            case (state)
                ST_IDLE: begin
                    if (accept && src == SRC_MEM) begin
                        state      <= ST_MEM_ISSUE;
                        o_mem_addr <= i_req[ADDR_LSB +: NB_ADDR];
                        cnt        <= i_req[LEN_LSB +: LEN_W];
                        lat        <= 1'b0;
                        snap       <= i_latch;
                    end else if (accept && src <= SRC_W'(N_CH)) begin
                        state <= ST_PRESENT;
                        ch    <= src - SRC_W'(1);
                        cnt   <= '0;
                        lat   <= 1'b1;
                        snap  <= i_latch;
                    end
                end
                ST_MEM_ISSUE: state <= ST_MEM_WAIT;
                ST_MEM_WAIT: begin
                    if (lat_done) begin
                        mem_word <= i_mem_data;
                        state    <= ST_PRESENT;
                    end
                end
                default: begin
                    if (i_tx_ready) begin
                        if (cnt != '0) begin
                            cnt        <= cnt - LEN_W'(1);
                            o_mem_addr <= o_mem_addr + NB_ADDR'(1);
                            state      <= ST_MEM_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_debug_port.sv
// tb_spi_debug_port: directed vectors for memory bursts, latch snapshots, backpressure, drop/error and reset
module tb_spi_debug_port;
    localparam int NB_BITS = 32;
    localparam int N_CH    = 4;
    localparam int NB_ADDR = 8;
    localparam int LAT     = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    req_valid;
    logic [NB_BITS-1:0]      req;
    logic [N_CH*NB_BITS-1:0] latch;
    logic [NB_ADDR-1:0]      mem_addr;
    logic                    mem_rd;
    logic [NB_BITS-1:0]      mem_data;
    logic [NB_BITS-1:0]      tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic                    busy;
    logic                    req_drop;
    logic                    err;

    logic [NB_BITS-1:0] mem [256];
    logic [NB_BITS-1:0] mem_q0, mem_q1;
    logic [NB_BITS-1:0] got_q [$];
    logic [NB_ADDR-1:0] rd_q [$];
    int n_vec = 0;
    int n_err = 0;

    spi_debug_port #(
        .NB_BITS (NB_BITS),
        .N_CH    (N_CH),
        .NB_ADDR (NB_ADDR),
        .MEM_LAT (LAT)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_req_valid (req_valid),
        .i_req       (req),
        .i_latch     (latch),
        .o_mem_addr  (mem_addr),
        .o_mem_rd    (mem_rd),
        .i_mem_data  (mem_data),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .o_busy      (busy),
        .o_req_drop  (req_drop),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    // two-cycle memory read pipeline; garbage on the bus when no read was issued
    always @(posedge clk) begin
        mem_q0 <= mem_rd ? mem[mem_addr] : 32'hDEAD_BEEF;
        mem_q1 <= mem_q0;
    end
    assign mem_data = mem_q1;

    // record transfers and read strobes mid-cycle
    always @(negedge clk) begin
        if (tx_valid && tx_ready) got_q.push_back(tx_data);
        if (mem_rd) rd_q.push_back(mem_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NB_BITS-1:0] r);
        req_valid = 1'b1;
        req = r;
        tick();
        req_valid = 1'b0;
        req = '0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) tick();
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic clear_q();
        got_q.delete();
        rd_q.delete();
    endtask

    function automatic logic [31:0] got_at(input int i);
        return i < got_q.size() ? got_q[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] rd_at(input int i);
        return i < rd_q.size() ? 32'(rd_q[i]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        logic [7:0] wrap_addr [4];
        wrap_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        for (int a = 0; a < 256; a++) mem[a] = 32'hCAFE_0000 | 32'(a);
        rst = 1'b1;
        req_valid = 1'b0;
        req = '0;
        latch = '0;
        tx_ready = 1'b0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ctrl", {27'd0, tx_valid, mem_rd, req_drop, err, busy}, 32'd0);
        check("rst_txdata", tx_data, 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;
        tick();

        // single memory read with exact timing
        tx_ready = 1'b1;
        clear_q();
        send(32'h0000_0005);
        check("single_rd", {31'd0, mem_rd}, 32'd1);
        check("single_addr", 32'(mem_addr), 32'd5);
        check("single_busy", {31'd0, busy}, 32'd1);
        tick();
        check("single_rd_once", {31'd0, mem_rd}, 32'd0);
        tick();
        check("single_wait", {31'd0, tx_valid}, 32'd0);
        tick();
        check("single_valid", {31'd0, tx_valid}, 32'd1);
        check("single_data", tx_data, 32'hCAFE_0005);
        tick();
        check("single_done", {30'd0, busy, tx_valid}, 32'd0);
        check("single_n", 32'(got_q.size()), 32'd1);

        // burst wrapping past the top of the address space
        clear_q();
        send(32'h0003_02FE);
        wait_idle();
        check("wrap_n", 32'(got_q.size()), 32'd4);
        check("wrap_rd_n", 32'(rd_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap_addr%0d", i), rd_at(i), 32'(wrap_addr[i]));
            check($sformatf("wrap_data%0d", i), got_at(i), 32'hCAFE_0000 | 32'(wrap_addr[i]));
        end

        // latch snapshot held under backpressure
        clear_q();
        tx_ready = 1'b0;
        latch[0 +: 32]  = 32'hA5A5_0001;
        latch[32 +: 32] = 32'hA5A5_0002;
        latch[64 +: 32] = 32'h1111_2222;
        latch[96 +: 32] = 32'h3333_4444;
        send(32'h0300_0000);
        latch = '0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_valid%0d", i), {31'd0, tx_valid}, 32'd1);
            check($sformatf("bp_data%0d", i), tx_data, 32'h1111_2222);
            tick();
        end
        check("bp_none", 32'(got_q.size()), 32'd0);
        tx_ready = 1'b1;
        tick();
        check("bp_drop_valid", {30'd0, busy, tx_valid}, 32'd0);
        check("bp_n", 32'(got_q.size()), 32'd1);
        check("bp_word", got_at(0), 32'h1111_2222);

        // last channel, LEN ignored
        clear_q();
        latch[96 +: 32] = 32'h3333_4444;
        send(32'h04FF_0000);
        latch = '0;
        wait_idle();
        check("ch4_n", 32'(got_q.size()), 32'd1);
        check("ch4_word", got_at(0), 32'h3333_4444);
        check("ch4_no_rd", 32'(rd_q.size()), 32'd0);

        // collision during a burst
        clear_q();
        send(32'h0001_0010);
        send(32'h0000_0020);
        check("drop_pulse", {31'd0, req_drop}, 32'd1);
        tick();
        check("drop_end", {31'd0, req_drop}, 32'd0);
        wait_idle();
        check("drop_n", 32'(got_q.size()), 32'd2);
        check("drop_w0", got_at(0), 32'hCAFE_0010);
        check("drop_w1", got_at(1), 32'hCAFE_0011);

        // invalid sources
        clear_q();
        send(32'h0700_0000);
        check("err7_pulse", {30'd0, err, busy}, 32'd2);
        tick();
        check("err7_end", {30'd0, err, tx_valid}, 32'd0);
        send(32'h0500_0000);
        check("err5_pulse", {30'd0, err, busy}, 32'd2);
        tick();
        check("err_none", 32'(got_q.size()), 32'd0);

        // reset in the latency wait of the second word
        clear_q();
        send(32'h0003_0040);
        for (int i = 0; i < 5; i++) tick();
        check("mid_state", {30'd0, busy, mem_rd}, 32'd2);
        check("mid_n", 32'(got_q.size()), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_ctrl", {27'd0, tx_valid, mem_rd, req_drop, err, busy}, 32'd0);
        check("mid_rst_data", tx_data, 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        tick();
        tick();
        tick();
        check("mid_discard", {30'd0, busy, tx_valid}, 32'd0);
        check("mid_n_after", 32'(got_q.size()), 32'd1);
        send(32'h0000_0007);
        wait_idle();
        check("post_n", 32'(got_q.size()), 32'd2);
        check("post_word", got_at(1), 32'hCAFE_0007);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
